// File: rtl/data_bridge_rd_reorder.sv
// Read channel of the data bridge: issues one tagged DMA read per request beat.
// It parks out-of-order responses per tag and returns them to the local side in request order.
module data_bridge_rd_reorder #(
   parameter  int IDW  = 3,
   parameter  int TAGW = 6,
   parameter  int DW   = 1024,
   localparam int BW   = DW / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lcl_addr_valid,
   output logic              lcl_addr_ready,
   input  logic [63:0]       lcl_addr_ea,
   input  logic [IDW-1:0]    lcl_addr_axi_id,
   input  logic [BW-1:0]     lcl_addr_be,
   input  logic              lcl_addr_last,
   output logic              lcl_data_valid,
   input  logic              lcl_data_ready,
   output logic [DW-1:0]     lcl_data,
   output logic [IDW-1:0]    lcl_data_axi_id,
   output logic              lcl_data_last,
   output logic              lcl_rsp_code,
   output logic              dma_cmd_valid,
   input  logic              dma_cmd_ready,
   output logic [63:0]       dma_cmd_ea,
   output logic [BW-1:0]     dma_cmd_be,
   output logic [5:0]        dma_cmd_tag,
   input  logic              dma_resp_valid,
   input  logic [5:0]        dma_resp_tag,
   input  logic [DW-1:0]     dma_resp_data,
   input  logic [2:0]        dma_resp_code,
   input  logic              context_update_ongoing,
   output logic              buf_empty,
   input  logic              debug_cnt_clear,
   output logic [31:0]       debug_cnt_cmd,
   output logic [31:0]       debug_cnt_rsp,
   output logic [TAGW:0]     debug_outstanding,
   output logic              fir_unexpected_tag
);

   localparam int         DEPTH     = 1 << TAGW;
   localparam logic [6:0] DEPTH_TAG = 7'(DEPTH);

   typedef logic [TAGW:0]   ptr_t;
   typedef logic [TAGW-1:0] idx_t;

   typedef struct packed {
      logic [IDW-1:0] axi_id;
      logic           last;
   } meta_t;

   ptr_t             alloc_ptr;
   ptr_t             retire_ptr;
   ptr_t             outstanding;
   idx_t             alloc_idx;
   idx_t             retire_idx;
   idx_t             rsp_idx;
   idx_t             rsp_offset;
   logic             full;
   logic             accept;
   logic             retire;
   logic             deliver;
   logic             rsp_in_range;
   logic             rsp_outstanding;
   logic             rsp_store;
   logic [DEPTH-1:0] done_q;
   logic [DEPTH-1:0] err_q;
   meta_t            meta_mem [DEPTH];
   logic [DW-1:0]    data_mem [DEPTH];

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign outstanding = alloc_ptr - retire_ptr;
   assign full        = (outstanding == ptr_t'(DEPTH));
   assign alloc_idx   = alloc_ptr[TAGW-1:0];
   assign retire_idx  = retire_ptr[TAGW-1:0];

   assign lcl_addr_ready = !full && !context_update_ongoing && (!dma_cmd_valid || dma_cmd_ready);
   assign accept         = lcl_addr_valid && lcl_addr_ready;
   assign deliver        = lcl_data_valid && lcl_data_ready;
   assign retire         = done_q[retire_idx] && (!lcl_data_valid || lcl_data_ready);

   // A response is legal only for an in-range tag between retire and alloc that is not yet done.
   assign rsp_idx         = dma_resp_tag[TAGW-1:0];
   assign rsp_offset      = rsp_idx - retire_idx;
   assign rsp_in_range    = ({1'b0, dma_resp_tag} < DEPTH_TAG);
   assign rsp_outstanding = ({1'b0, rsp_offset} < outstanding);
   assign rsp_store       = dma_resp_valid && rsp_in_range && rsp_outstanding && !done_q[rsp_idx];

   assign buf_empty         = (outstanding == '0) && !dma_cmd_valid && !lcl_data_valid;
   assign debug_outstanding = outstanding;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alloc_ptr  <= '0;
         retire_ptr <= '0;
      end else begin
         alloc_ptr  <= alloc_ptr + ptr_t'(accept);
         retire_ptr <= retire_ptr + ptr_t'(retire);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         done_q <= '0;
         err_q  <= '0;
      end else begin
         if (rsp_store) begin
            done_q[rsp_idx] <= 1'b1;
            err_q[rsp_idx]  <= (dma_resp_code != 3'd0);
         end
         if (retire)
            done_q[retire_idx] <= 1'b0;
         if (accept)
            done_q[alloc_idx] <= 1'b0;
      end
   end

   // NOTE: the storage arrays have no reset; done_q gates every read, so stale contents never escape.
   always_ff @(posedge clk) begin
      if (accept)
         meta_mem[alloc_idx] <= '{axi_id: lcl_addr_axi_id, last: lcl_addr_last};
      if (rsp_store)
         data_mem[rsp_idx] <= dma_resp_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dma_cmd_valid <= 1'b0;
         dma_cmd_ea    <= '0;
         dma_cmd_be    <= '0;
         dma_cmd_tag   <= '0;
      end else if (accept) begin
         dma_cmd_valid <= 1'b1;
         dma_cmd_ea    <= lcl_addr_ea;
         dma_cmd_be    <= lcl_addr_be;
         dma_cmd_tag   <= 6'(alloc_idx);
      end else if (dma_cmd_ready) begin
         dma_cmd_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lcl_data_valid  <= 1'b0;
         lcl_data        <= '0;
         lcl_data_axi_id <= '0;
         lcl_data_last   <= 1'b0;
         lcl_rsp_code    <= 1'b0;
      end else if (retire) begin
         lcl_data_valid  <= 1'b1;
         lcl_data        <= data_mem[retire_idx];
         lcl_data_axi_id <= meta_mem[retire_idx].axi_id;
         lcl_data_last   <= meta_mem[retire_idx].last;
         lcl_rsp_code    <= err_q[retire_idx];
      end else if (lcl_data_ready) begin
         lcl_data_valid  <= 1'b0;
      end
   end

   // Saturating debug counters; clear wins over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (!rst_n || debug_cnt_clear) begin
         debug_cnt_cmd <= '0;
         debug_cnt_rsp <= '0;
      end else begin
         if (accept && (debug_cnt_cmd != '1))
            debug_cnt_cmd <= debug_cnt_cmd + 32'd1;
         if (deliver && (debug_cnt_rsp != '1))
            debug_cnt_rsp <= debug_cnt_rsp + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         fir_unexpected_tag <= 1'b0;
      else if (dma_resp_valid && !rsp_store)
         fir_unexpected_tag <= 1'b1;
   end

endmodule

// File: tb/tb_data_bridge_rd_reorder.sv
// Scoreboard bench for data_bridge_rd_reorder: a DMA memory model answers commands in
// random order and beats must come back in request order with the modelled data.
module tb_data_bridge_rd_reorder;

   localparam int IDW   = 3;
   localparam int TAGW  = 2;
   localparam int DW    = 64;
   localparam int BW    = DW / 8;
   localparam int DEPTH = 1 << TAGW;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            lcl_addr_valid = 1'b0;
   logic            lcl_addr_ready;
   logic [63:0]     lcl_addr_ea = '0;
   logic [IDW-1:0]  lcl_addr_axi_id = '0;
   logic [BW-1:0]   lcl_addr_be = '0;
   logic            lcl_addr_last = 1'b0;
   logic            lcl_data_valid;
   logic            lcl_data_ready = 1'b0;
   logic [DW-1:0]   lcl_data;
   logic [IDW-1:0]  lcl_data_axi_id;
   logic            lcl_data_last;
   logic            lcl_rsp_code;
   logic            dma_cmd_valid;
   logic            dma_cmd_ready = 1'b0;
   logic [63:0]     dma_cmd_ea;
   logic [BW-1:0]   dma_cmd_be;
   logic [5:0]      dma_cmd_tag;
   logic            dma_resp_valid = 1'b0;
   logic [5:0]      dma_resp_tag = '0;
   logic [DW-1:0]   dma_resp_data = '0;
   logic [2:0]      dma_resp_code = '0;
   logic            context_update_ongoing = 1'b0;
   logic            buf_empty;
   logic            debug_cnt_clear = 1'b0;
   logic [31:0]     debug_cnt_cmd;
   logic [31:0]     debug_cnt_rsp;
   logic [TAGW:0]   debug_outstanding;
   logic            fir_unexpected_tag;

   data_bridge_rd_reorder #(.IDW(IDW), .TAGW(TAGW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .lcl_addr_valid(lcl_addr_valid), .lcl_addr_ready(lcl_addr_ready),
      .lcl_addr_ea(lcl_addr_ea), .lcl_addr_axi_id(lcl_addr_axi_id),
      .lcl_addr_be(lcl_addr_be), .lcl_addr_last(lcl_addr_last),
      .lcl_data_valid(lcl_data_valid), .lcl_data_ready(lcl_data_ready),
      .lcl_data(lcl_data), .lcl_data_axi_id(lcl_data_axi_id),
      .lcl_data_last(lcl_data_last), .lcl_rsp_code(lcl_rsp_code),
      .dma_cmd_valid(dma_cmd_valid), .dma_cmd_ready(dma_cmd_ready),
      .dma_cmd_ea(dma_cmd_ea), .dma_cmd_be(dma_cmd_be), .dma_cmd_tag(dma_cmd_tag),
      .dma_resp_valid(dma_resp_valid), .dma_resp_tag(dma_resp_tag),
      .dma_resp_data(dma_resp_data), .dma_resp_code(dma_resp_code),
      .context_update_ongoing(context_update_ongoing), .buf_empty(buf_empty),
      .debug_cnt_clear(debug_cnt_clear), .debug_cnt_cmd(debug_cnt_cmd),
      .debug_cnt_rsp(debug_cnt_rsp), .debug_outstanding(debug_outstanding),
      .fir_unexpected_tag(fir_unexpected_tag)
   );

   always #5 clk = ~clk;

   typedef struct { logic [63:0] ea; logic [BW-1:0] be; logic [5:0] tag; } cmd_exp_t;
   typedef struct { logic [IDW-1:0] id; logic last; logic [DW-1:0] data; logic code; } beat_exp_t;
   typedef struct { logic bogus; logic [5:0] tag; logic [DW-1:0] data; } inj_t;

   cmd_exp_t    exp_cmd_q[$];
   beat_exp_t   exp_beat_q[$];
   inj_t        inj_q[$];
   logic [5:0]  pend_tag[$];
   logic [63:0] pend_ea[$];

   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   acc_cnt = 0;
   int   resp_cyc = 0;
   logic auto_rsp = 1'b0;
   logic rnd_rdy = 1'b0;
   logic data_rdy_hold = 1'b1;
   logic cmd_rdy_hold = 1'b1;
   logic bg_done = 1'b0;

   // The DMA target behaves like a memory: data and response code are pure functions of the address.
   function automatic logic [DW-1:0] mem_data(input logic [63:0] ea);
      return (ea * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
   endfunction

   function automatic logic [2:0] mem_code(input logic [63:0] ea);
      return ea[2:0];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (rnd_rdy) begin
         lcl_data_ready = ~lcl_data_ready;
         dma_cmd_ready  = ($urandom_range(0, 2) != 0);
      end else begin
         lcl_data_ready = data_rdy_hold;
         dma_cmd_ready  = cmd_rdy_hold;
      end
   end

   always @(negedge clk) begin : cmd_mon
      cmd_exp_t e;
      if (rst_n && dma_cmd_valid && dma_cmd_ready) begin
         check("cmd_expected", 64'(exp_cmd_q.size() != 0), 1);
         if (exp_cmd_q.size() != 0) begin
            e = exp_cmd_q.pop_front();
            check("cmd_ea", dma_cmd_ea, e.ea);
            check("cmd_be", 64'(dma_cmd_be), 64'(e.be));
            check("cmd_tag", 64'(dma_cmd_tag), 64'(e.tag));
         end
         pend_tag.push_back(dma_cmd_tag);
         pend_ea.push_back(dma_cmd_ea);
      end
   end

   always @(negedge clk) begin : data_mon
      beat_exp_t e;
      if (rst_n && lcl_data_valid && lcl_data_ready) begin
         check("beat_expected", 64'(exp_beat_q.size() != 0), 1);
         if (exp_beat_q.size() != 0) begin
            e = exp_beat_q.pop_front();
            check("beat_id", 64'(lcl_data_axi_id), 64'(e.id));
            check("beat_last", 64'(lcl_data_last), 64'(e.last));
            check("beat_data", lcl_data, e.data);
            check("beat_rsp_code", 64'(lcl_rsp_code), 64'(e.code));
         end
      end
   end

   always @(posedge clk) begin : responder
      inj_t        f;
      int          idx;
      logic [63:0] ea;
      #1;
      dma_resp_valid = 1'b0;
      dma_resp_tag   = '0;
      dma_resp_data  = '0;
      dma_resp_code  = '0;
      idx = -1;
      if (rst_n && inj_q.size() != 0) begin
         f = inj_q.pop_front();
         if (f.bogus) begin
            dma_resp_valid = 1'b1;
            dma_resp_tag   = f.tag;
            dma_resp_data  = f.data;
         end else begin
            foreach (pend_tag[i])
               if (idx < 0 && pend_tag[i] == f.tag) idx = i;
            check("injected_tag_pending", 64'(idx >= 0), 1);
         end
      end else if (rst_n && auto_rsp && pend_tag.size() != 0 && $urandom_range(0, 3) != 0) begin
         idx = $urandom_range(0, pend_tag.size() - 1);
      end
      if (idx >= 0) begin
         ea = pend_ea[idx];
         dma_resp_valid = 1'b1;
         dma_resp_tag   = pend_tag[idx];
         dma_resp_data  = mem_data(ea);
         dma_resp_code  = mem_code(ea);
         pend_tag.delete(idx);
         pend_ea.delete(idx);
         resp_cyc = cyc;
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic inject(input logic bogus, input logic [5:0] tag, input logic [DW-1:0] data);
      inj_q.push_back('{bogus: bogus, tag: tag, data: data});
   endtask

   task automatic send_req(input logic [63:0] ea, input logic [IDW-1:0] id,
                           input logic [BW-1:0] be, input logic last, output logic ok);
      lcl_addr_valid  = 1'b1;
      lcl_addr_ea     = ea;
      lcl_addr_axi_id = id;
      lcl_addr_be     = be;
      lcl_addr_last   = last;
      ok = 1'b0;
      for (int n = 0; n < 5000 && !ok; n++) begin
         @(negedge clk);
         if (rst_n && lcl_addr_ready) begin
            exp_cmd_q.push_back('{ea, be, 6'(acc_cnt % DEPTH)});
            exp_beat_q.push_back('{id, last, mem_data(ea), (mem_code(ea) != 3'd0)});
            acc_cnt++;
            ok = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      lcl_addr_valid = 1'b0;
   endtask

   task automatic wait_pend(input string name, input int count);
      int n = 0;
      while (pend_tag.size() < count && n < 50) begin
         wait_cycles(1);
         n++;
      end
      check(name, 64'(pend_tag.size()), 64'(count));
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while (!(buf_empty && exp_beat_q.size() == 0 && inj_q.size() == 0) && n < budget) begin
         wait_cycles(1);
         n++;
      end
      check(name, 64'(buf_empty && exp_beat_q.size() == 0), 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      lcl_addr_valid = 1'b0;
      auto_rsp = 1'b0;
      inj_q.delete();
      pend_tag.delete();
      pend_ea.delete();
      exp_cmd_q.delete();
      exp_beat_q.delete();
      acc_cnt = 0;
      wait_cycles(3);
      rst_n = 1'b1;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic ok;
      logic ok_bg;
      int   n;
      logic [63:0] ea;

      // Reset state
      wait_cycles(1);
      do_reset();
      check("rst_data_valid", 64'(lcl_data_valid), 0);
      check("rst_cmd_valid", 64'(dma_cmd_valid), 0);
      check("rst_cmd_tag", 64'(dma_cmd_tag), 0);
      check("rst_data", lcl_data, 0);
      check("rst_fir", 64'(fir_unexpected_tag), 0);
      check("rst_cnt_cmd", 64'(debug_cnt_cmd), 0);
      check("rst_cnt_rsp", 64'(debug_cnt_rsp), 0);
      check("rst_outstanding", 64'(debug_outstanding), 0);
      check("rst_buf_empty", 64'(buf_empty), 1);
      check("rst_addr_ready", 64'(lcl_addr_ready), 1);

      // Single beat with a two-cycle response latency
      send_req(64'h1000, 3'd5, '1, 1'b1, ok);
      check("t1_accept", 64'(ok), 1);
      wait_pend("t1_cmd_issued", 1);
      wait_cycles(2);
      inject(1'b0, 6'd0, '0);
      n = 0;
      while (!lcl_data_valid && n < 20) begin
         wait_cycles(1);
         n++;
      end
      check("t1_data_valid_seen", 64'(lcl_data_valid), 1);
      check("t1_resp_latency", 64'(cyc - resp_cyc), 2);
      wait_cycles(3);
      check("t1_cnt_cmd", 64'(debug_cnt_cmd), 1);
      check("t1_cnt_rsp", 64'(debug_cnt_rsp), 1);
      check("t1_buf_empty", 64'(buf_empty), 1);

      // Fill all four tags, hold the fifth, answer out of order
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send_req(64'h4000 + 64'(i * 64), IDW'(i + 1), BW'($urandom), i[0], ok);
         check("t2_accept", 64'(ok), 1);
      end
      bg_done = 1'b0;
      fork
         begin
            send_req(64'h5000, 3'd6, '1, 1'b1, ok_bg);
            bg_done = 1'b1;
         end
      join_none
      wait_cycles(4);
      check("t2_full_ready_low", 64'(lcl_addr_ready), 0);
      check("t2_outstanding_full", 64'(debug_outstanding), 4);
      check("t2_fifth_held", 64'(bg_done), 0);
      inject(1'b0, 6'd3, '0);
      inject(1'b0, 6'd1, '0);
      inject(1'b0, 6'd2, '0);
      inject(1'b0, 6'd0, '0);
      n = 0;
      while (!bg_done && n < 50) begin
         wait_cycles(1);
         n++;
      end
      check("t2_fifth_accepted", 64'(bg_done && ok_bg), 1);
      wait_pend("t2_fifth_cmd", 1);
      inject(1'b0, 6'd0, '0);
      wait_drain("t2_drain", 100);

      // Error response on the second beat of a burst
      do_reset();
      send_req(64'h2000, 3'd2, '1, 1'b0, ok);
      send_req(64'h2043, 3'd2, '1, 1'b1, ok);
      wait_pend("t3_cmds", 2);
      inject(1'b0, 6'd1, '0);
      inject(1'b0, 6'd0, '0);
      wait_drain("t3_drain", 100);

      // Out-of-range, not-outstanding and duplicate tags are dropped and flagged
      do_reset();
      check("t4_fir_clear", 64'(fir_unexpected_tag), 0);
      data_rdy_hold = 1'b0;
      send_req(64'h3000, 3'd1, '1, 1'b0, ok);
      send_req(64'h3008, 3'd3, '1, 1'b1, ok);
      wait_pend("t4_cmds", 2);
      inject(1'b1, 6'd5, 64'hDEAD);
      inject(1'b0, 6'd1, '0);
      inject(1'b1, 6'd1, 64'hBAD0_BAD0);
      inject(1'b1, 6'd2, 64'hBEEF);
      wait_cycles(8);
      check("t4_fir_set", 64'(fir_unexpected_tag), 1);
      check("t4_head_not_ready", 64'(lcl_data_valid), 0);
      inject(1'b0, 6'd0, '0);
      data_rdy_hold = 1'b1;
      wait_drain("t4_drain", 100);
      check("t4_fir_sticky", 64'(fir_unexpected_tag), 1);
      do_reset();
      check("t4_fir_reset", 64'(fir_unexpected_tag), 0);

      // Context update blocks acceptance but not completion
      for (int i = 0; i < 3; i++)
         send_req(64'h6000 + 64'(i * 8), IDW'(i), '1, 1'b0, ok);
      context_update_ongoing = 1'b1;
      bg_done = 1'b0;
      fork
         begin
            send_req(64'h6100, 3'd7, '1, 1'b1, ok_bg);
            bg_done = 1'b1;
         end
      join_none
      wait_cycles(3);
      check("t5_ctx_ready_low", 64'(lcl_addr_ready), 0);
      check("t5_outstanding", 64'(debug_outstanding), 3);
      inject(1'b0, 6'd2, '0);
      inject(1'b0, 6'd0, '0);
      inject(1'b0, 6'd1, '0);
      wait_drain("t5_drain_under_ctx", 100);
      check("t5_still_blocked", 64'(bg_done), 0);
      context_update_ongoing = 1'b0;
      wait_cycles(2);
      check("t5_accept_after_ctx", 64'(bg_done), 1);
      wait_pend("t5_last_cmd", 1);
      inject(1'b0, 6'd3, '0);
      wait_drain("t5_drain", 100);

      // Random traffic with random DMA ordering and back-pressure
      do_reset();
      auto_rsp = 1'b1;
      rnd_rdy  = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         ea = {$urandom, $urandom} & ~64'h7;
         if ($urandom_range(0, 7) == 0)
            ea[2:0] = 3'($urandom_range(1, 7));
         send_req(ea, IDW'($urandom), BW'($urandom), 1'($urandom), ok);
         check("t6_accept", 64'(ok), 1);
         if ($urandom_range(0, 3) == 0)
            wait_cycles($urandom_range(1, 3));
      end
      wait_drain("t6_drain", 20000);
      rnd_rdy = 1'b0;
      wait_cycles(2);
      check("t6_cnt_cmd", 64'(debug_cnt_cmd), 1000);
      check("t6_cnt_rsp", 64'(debug_cnt_rsp), 1000);
      check("t6_outstanding", 64'(debug_outstanding), 0);
      debug_cnt_clear = 1'b1;
      wait_cycles(1);
      debug_cnt_clear = 1'b0;
      check("t6_cnt_cmd_cleared", 64'(debug_cnt_cmd), 0);
      check("t6_cnt_rsp_cleared", 64'(debug_cnt_rsp), 0);
      check("t6_fir_clean", 64'(fir_unexpected_tag), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
